// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared types and constants for the bounce counter controller
//
// Purpose : state encoding, direction constants, lap counter width and the
//           count-register operation codes used by contador_ctrl/contador_dp.
// Ports   : none (package).

package contador_pkg;

   localparam int   LAPS_W   = 8;
   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      UP       = 3'd1,
      DWELL_HI = 3'd2,
      DOWN     = 3'd3,
      DWELL_LO = 3'd4
   } state_t;

   // Operation applied to the count register on the next edge.
   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_LOAD = 2'd1,
      CNT_INC  = 2'd2,
      CNT_DEC  = 2'd3
   } cnt_op_t;

endpackage

// File: rtl/contador_dp.sv
// rtl/contador_dp.sv - count register of the bounce counter datapath
//
// Purpose : holds the current count and applies load/inc/dec/hold as
//           commanded by the controller.
// Ports   : clk, rst_n         clock, async active-low reset
//           cnt_op             operation for the next edge
//           load_val [WIDTH]   value taken on CNT_LOAD
//           count    [WIDTH]   registered count

module contador_dp
   import contador_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  cnt_op_t          cnt_op,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         case (cnt_op)
            CNT_LOAD: count <= load_val;
            CNT_INC:  count <= count + WIDTH'(1);
            CNT_DEC:  count <= count - WIDTH'(1);
            default:  count <= count;
         endcase
      end
   end

endmodule

// File: rtl/contador_ctrl.sv
// rtl/contador_ctrl.sv - sequencing controller for the bounce (up/down) counter
//
// Purpose : latches lo/hi/lap configuration, runs the count between the
//           limits with DWELL extra hold cycles at each endpoint, reports
//           reversals (turn) and final-lap completion (done); pause freezes
//           the run, stop aborts to IDLE.
// Ports   : clk, rst_n                      clock, async active-low reset
//           cfg_valid/cfg_ready             config handshake (ready = IDLE)
//           cfg_lo, cfg_hi [WIDTH]          limits, accepted only if lo < hi
//           cfg_laps [8]                    laps to run, 0 = until stop
//           cfg_err                         pulse after a rejected config
//           start, pause, stop              run control
//           count [WIDTH], dir              current count, 0 = up / 1 = down
//           busy, turn, done                run status and event pulses

module contador_ctrl
   import contador_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DWELL = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [WIDTH-1:0]  cfg_lo,
   input  logic [WIDTH-1:0]  cfg_hi,
   input  logic [LAPS_W-1:0] cfg_laps,
   output logic              cfg_err,
   input  logic              start,
   input  logic              pause,
   input  logic              stop,
   output logic [WIDTH-1:0]  count,
   output logic              dir,
   output logic              busy,
   output logic              turn,
   output logic              done
);

   // The dwell counter holds "remaining extra cycles - 1", so it only needs
   // to represent 0..DWELL-1.
   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'((DWELL > 0) ? DWELL - 1 : 0);

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  lo_q, hi_q;
   logic [LAPS_W-1:0] laps_q, lap_q, lap_d;
   logic [DW_W-1:0]   dwell_q, dwell_d;
   logic              dir_d, turn_d, done_d, busy_d;
   cnt_op_t           cnt_op;
   logic [WIDTH-1:0]  load_val;
   logic              cfg_hs, cfg_ok, cfg_take;
   logic              final_lap, step_onto_lo;

   contador_dp #(.WIDTH(WIDTH)) u_dp (
      .clk      (clk),
      .rst_n    (rst_n),
      .cnt_op   (cnt_op),
      .load_val (load_val),
      .count    (count)
   );

   assign cfg_ready = (state_q == IDLE);

   // stop outranks config, so a handshake is not taken while stop is high.
   assign cfg_hs   = cfg_valid && cfg_ready && !stop;
   assign cfg_ok   = (cfg_lo < cfg_hi);
   assign cfg_take = cfg_hs && cfg_ok;

   assign final_lap = (laps_q != '0) && (lap_q == laps_q);

   // Only meaningful while decrementing, where count > lo always holds.
   assign step_onto_lo = (count == lo_q + WIDTH'(1));

   always_comb begin
      state_d  = state_q;
      cnt_op   = CNT_HOLD;
      // A config taken in the same IDLE cycle as start supplies the new lo.
      load_val = cfg_take ? cfg_lo : lo_q;
      dir_d    = dir;
      turn_d   = 1'b0;
      done_d   = 1'b0;
      dwell_d  = dwell_q;
      lap_d    = lap_q;

      if (stop) begin
         state_d = IDLE;
      end else if (!(pause && (state_q != IDLE))) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = UP;
                  cnt_op  = CNT_LOAD;
                  dir_d   = DIR_UP;
                  lap_d   = '0;
               end
            end

            UP: begin
               if (count == hi_q) begin
                  if (DWELL == 0) begin
                     state_d = DOWN;
                     cnt_op  = CNT_DEC;
                     dir_d   = DIR_DOWN;
                     turn_d  = 1'b1;
                  end else begin
                     state_d = DWELL_HI;
                     dwell_d = DWELL_LAST;
                  end
               end else begin
                  cnt_op = CNT_INC;
               end
            end

            DWELL_HI: begin
               if (dwell_q == '0) begin
                  state_d = DOWN;
                  cnt_op  = CNT_DEC;
                  dir_d   = DIR_DOWN;
                  turn_d  = 1'b1;
               end else begin
                  dwell_d = dwell_q - DW_W'(1);
               end
            end

            DOWN: begin
               if (count == lo_q) begin
                  if (final_lap) begin
                     state_d = IDLE;
                  end else if (DWELL == 0) begin
                     state_d = UP;
                     cnt_op  = CNT_INC;
                     dir_d   = DIR_UP;
                     turn_d  = 1'b1;
                  end else begin
                     state_d = DWELL_LO;
                     dwell_d = DWELL_LAST;
                  end
               end else begin
                  cnt_op = CNT_DEC;
               end
            end

            DWELL_LO: begin
               if (dwell_q == '0) begin
                  state_d = UP;
                  cnt_op  = CNT_INC;
                  dir_d   = DIR_UP;
                  turn_d  = 1'b1;
               end else begin
                  dwell_d = dwell_q - DW_W'(1);
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase

         // A lap completes on the step that lands on lo. This may be the
         // first down step (hi == lo+1), so it is decoded from the count
         // operation rather than from the DOWN state alone. done is issued
         // here so it coincides with the final lo; IDLE follows one cycle
         // later from the DOWN branch above.
         if ((cnt_op == CNT_DEC) && step_onto_lo && (laps_q != '0)) begin
            lap_d  = lap_q + LAPS_W'(1);
            done_d = (lap_d == laps_q);
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dwell_q <= '0;
         lap_q   <= '0;
         dir     <= DIR_UP;
         busy    <= 1'b0;
         turn    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
         lap_q   <= lap_d;
         dir     <= dir_d;
         busy    <= busy_d;
         turn    <= turn_d;
         done    <= done_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_q    <= '0;
         hi_q    <= '1;
         laps_q  <= '0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_hs && !cfg_ok;
         if (cfg_take) begin
            lo_q   <= cfg_lo;
            hi_q   <= cfg_hi;
            laps_q <= cfg_laps;
         end
      end
   end

endmodule

// File: doc/contador_ctrl.md
# contador_ctrl

- Sequencing controller for the team's bounce (up/down) counter datapath.
- Accepts a configuration of lower limit, upper limit and lap count, and runs the counter between the limits on start.
- Holds the count at each endpoint for DWELL cycles, reports direction reversals and lap completion, and supports pause and stop.
- Sits between the control logic or test harness and the count display path.

## Interface
- WIDTH, 4, count width in bits
- DWELL, 1, extra cycles the count is held at each endpoint (0 = reverse immediately)
- clk  in  1  single system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  high only in IDLE
- cfg_lo  in  WIDTH  lower limit
- cfg_hi  in  WIDTH  upper limit
- cfg_laps  in  8  laps to run; 0 = run until stop
- cfg_err  out  1  one-cycle pulse when an offered config is rejected
- start  in  1  begin run; sampled in IDLE only
- pause  in  1  level; freezes run state while high
- stop  in  1  abort to IDLE
- count  out  WIDTH  current count
- dir  out  1  0 = up, 1 = down
- busy  out  1  high in any non-IDLE state
- turn  out  1  one-cycle pulse on a direction change
- done  out  1  one-cycle pulse when the final lap completes

## Operation
- **States:** IDLE, UP, DWELL_HI, DOWN, DWELL_LO.
- **Reset values:**
  - state IDLE, count 0, dir 0, busy 0, turn 0, done 0, cfg_err 0, cfg_ready 1.
  - Latched lo 0, hi 2^WIDTH-1, laps 0.
- **Config:**
  - A handshake occurs when cfg_valid && cfg_ready.
  - If cfg_lo < cfg_hi, latch lo/hi/laps.
  - Otherwise latch nothing and pulse cfg_err in the next cycle.
- **Start (IDLE):**
  - Next cycle: count=lo, dir=0, lap counter=0, state UP.
  - start while busy is ignored.
  - When cfg handshake and start are both sampled in the same IDLE cycle, config is latched first and the run uses the new limits.
- **UP:**
  - count+1 per cycle.
  - Once count==hi, hold hi for DWELL further cycles (DWELL_HI), then DOWN.
- **DOWN:**
  - count-1 per cycle.
  - On reaching lo, the lap counter increments.
  - If laps!=0 and lap counter==laps: pulse done in that cycle, then go to IDLE with count held at lo.
  - Otherwise hold lo for DWELL cycles (DWELL_LO), then UP.
- **turn / dir:** dir changes, and turn pulses, in the cycle the first step in the new direction appears on count. No turn is generated at start or at done.
- **Arithmetic:**
  - Count never leaves [lo, hi], so no wrap-around is possible.
  - The lap counter is 8-bit and is not incremented when laps=0.
- **Priority:** stop > pause > start/config.
  - stop in any state: next cycle IDLE, busy 0, count and dir retained, no done, no turn.
  - pause high in a non-IDLE state: count, dir, state, dwell and lap counters all frozen. Run resumes exactly where it was the cycle after pause falls.
  - pause in IDLE has no effect.
- **Reset mid-run:** asynchronous return to reset values. The previously latched config is lost.

## Timing
- start sampled at edge k: count=lo visible after edge k+1, busy high from the same edge.
- Endpoint hold: hi (and lo, between laps) is visible for 1+DWELL consecutive cycles.
- Lap length with lo=0, hi=15: 2·15 + 2·(1+DWELL) − 2 cycles, which is 32 cycles for DWELL=1.
- done is coincident with the final count==lo. busy falls one cycle later.
- cfg_err appears one cycle after the rejected handshake.
- All outputs are registered. There is no combinational path from inputs to outputs except cfg_ready, which is decoded from state.

## Structure
- **contador_pkg:**
  - state_t enum (IDLE, UP, DWELL_HI, DOWN, DWELL_LO).
  - DIR_UP/DIR_DOWN constants.
  - LAPS_W=8.
- **contador_dp (sub-module):**
  - Owns the count register and the load, inc, dec and hold controls.
  - contador_ctrl holds the FSM, dwell counter, lap counter and config registers.

## Test plan
- **Reset:** assert rst_n=0 mid-run → all outputs at reset values immediately; after release, cfg_ready=1.
- **Single lap:** config lo=0, hi=15, laps=1, DWELL=1, start at edge 0 →
  - count 0 at cycle 1 and 15 at cycles 16–17;
  - turn and dir=1 at cycle 18 (count 14);
  - count 0 with done at cycle 32, busy=0 at cycle 33.
- **Bad config:** lo=9, hi=9 → cfg_err pulse, latched limits unchanged. A following start runs 0..15.
- **Pause:** lo=3, hi=6, laps=0; hold pause for 5 cycles while count=5 going up → count stays 5 with dir 0; the next value after release is 6.
- **Stop:** stop while count=12 in DOWN → IDLE next cycle, count 12, busy 0, no done. A following start begins at lo.
- **DWELL=0, two laps, lo=2, hi=4:**
  - count sequence 2,3,4,3,2,3,4,3,2;
  - turn at each reversal;
  - done exactly once, on the final 2.
